// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid-buffer stage: occupancy states and the MEM/WB payload.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } state_e;

   typedef struct packed {
      logic        regWriteEnable;
      logic [31:0] instruction;
      logic [31:0] PC;
      logic [31:0] execute_rst;
      logic        memRead;
      logic [31:0] memReadRst;
   } memwb_payload_t;

   localparam int unsigned MEMWB_W = $bits(memwb_payload_t);

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value; cleared only by reset.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Registered valid/ready pipeline stage with a 2-entry skid buffer, flush and stall counter.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = MEMWB_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cycles
);

   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              in_fire, out_fire;
   state_e            state;

   assign in_ready  = !skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = main_valid_q && out_ready;

   // The illegal (0,1) encoding decodes as EMPTY, whose branch clears skid valid.
   always_comb begin
      state = EMPTY;
      if (main_valid_q) begin
         state = skid_valid_q ? FULL : ONE;
      end
   end

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      case (state)
         EMPTY: begin
            skid_valid_d = 1'b0;
            if (in_fire) begin
               main_valid_d = 1'b1;
               main_data_d  = in_data;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_data_d = in_data;
            end else if (in_fire) begin
               skid_valid_d = 1'b1;
               skid_data_d  = in_data;
            end else if (out_fire) begin
               main_valid_d = 1'b0;
            end
         end
         FULL: begin
            if (out_fire) begin
               main_data_d  = skid_data_q;
               skid_valid_d = 1'b0;
            end
         end
         default: begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
         end
      endcase
      // Flush overrides every handshake; any accepted input is simply dropped.
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         main_data_d  = '0;
         skid_data_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (main_valid_q && !out_ready),
      .count (stall_cycles)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_pipe_skid_reg;

   localparam int unsigned DW = 130;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, out_ready;
   logic [DW-1:0] in_data;

   logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [DW-1:0] out_data_a, out_data_b;
   logic [1:0]    occ_a, occ_b;
   logic [15:0]   stall_a;
   logic [3:0]    stall_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_skid_reg dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready_a),
      .in_data      (in_data),
      .out_valid    (out_valid_a),
      .out_ready    (out_ready),
      .out_data     (out_data_a),
      .occupancy    (occ_a),
      .stall_cycles (stall_a)
   );

   pipe_skid_reg #(
      .DATA_W (DW),
      .CNT_W  (4)
   ) dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready_b),
      .in_data      (in_data),
      .out_valid    (out_valid_b),
      .out_ready    (out_ready),
      .out_data     (out_data_b),
      .occupancy    (occ_b),
      .stall_cycles (stall_b)
   );

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a FIFO of at most two entries plus two saturating counters.
   logic [DW-1:0] mq[$];
   int unsigned   m_stall16, m_stall4;
   bit            m_init = 1'b0;

   initial begin
      bit m_in_ready, m_out_valid;
      forever begin
         @(negedge clk);
         if (m_init) begin
            chk("out_valid", 160'(out_valid_a), 160'(mq.size() > 0));
            chk("in_ready", 160'(in_ready_a), 160'(mq.size() < 2));
            chk("occupancy", 160'(occ_a), 160'(mq.size()));
            chk("stall16", 160'(stall_a), 160'(m_stall16));
            chk("stall4", 160'(stall_b), 160'(m_stall4));
            chk("occupancy_b", 160'(occ_b), 160'(mq.size()));
            if (mq.size() > 0) begin
               chk("out_data", 160'(out_data_a), 160'(mq[0]));
               chk("out_data_b", 160'(out_data_b), 160'(mq[0]));
            end
         end
         // Predict the state after the coming rising edge from the inputs now stable.
         if (!rst_n) begin
            mq.delete();
            m_stall16 = 0;
            m_stall4  = 0;
            m_init    = 1'b1;
         end else if (m_init) begin
            m_out_valid = (mq.size() > 0);
            m_in_ready  = (mq.size() < 2);
            if (m_out_valid && !out_ready) begin
               if (m_stall16 < 65535) m_stall16++;
               if (m_stall4 < 15) m_stall4++;
            end
            if (flush) begin
               mq.delete();
            end else begin
               if (m_out_valid && out_ready) void'(mq.pop_front());
               if (in_valid && m_in_ready) mq.push_back(in_data);
            end
         end
      end
   end

   initial begin
      logic [159:0] r;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = DW'(3);
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 160'(out_valid_a), 160'(0));
      chk("rst_in_ready", 160'(in_ready_a), 160'(1));
      chk("rst_out_data", 160'(out_data_a), 160'(0));
      chk("rst_occ", 160'(occ_a), 160'(0));
      chk("rst_stall", 160'(stall_a), 160'(0));

      // Streaming
      rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      in_data = DW'('hA1); tick();
      chk("stream_a1", 160'(out_data_a), 160'('hA1));
      chk("stream_occ", 160'(occ_a), 160'(1));
      in_data = DW'('hA2); tick();
      chk("stream_a2", 160'(out_data_a), 160'('hA2));
      chk("stream_rdy", 160'(in_ready_a), 160'(1));
      in_data = DW'('hA3); tick();
      chk("stream_a3", 160'(out_data_a), 160'('hA3));
      in_valid = 1'b0; tick();
      chk("stream_drain", 160'(occ_a), 160'(0));

      // Back-pressure
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = DW'('hB1); tick();
      chk("bp_stall0", 160'(stall_a), 160'(0));
      in_data = DW'('hB2); tick();
      chk("bp_occ2", 160'(occ_a), 160'(2));
      chk("bp_not_ready", 160'(in_ready_a), 160'(0));
      chk("bp_head_b1", 160'(out_data_a), 160'('hB1));
      chk("bp_stall1", 160'(stall_a), 160'(1));
      in_data = DW'('hB3); tick();
      chk("bp_stall2", 160'(stall_a), 160'(2));
      tick();
      chk("bp_stall3", 160'(stall_a), 160'(3));
      chk("bp_held_occ", 160'(occ_a), 160'(2));
      out_ready = 1'b1; tick();
      chk("bp_b2", 160'(out_data_a), 160'('hB2));
      chk("bp_occ1", 160'(occ_a), 160'(1));
      tick();
      chk("bp_b3", 160'(out_data_a), 160'('hB3));
      in_valid = 1'b0; tick();
      chk("bp_empty", 160'(out_valid_a), 160'(0));

      // Flush in FULL
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = DW'('hC1); tick();
      in_data = DW'('hC2); tick();
      chk("fl_full", 160'(occ_a), 160'(2));
      in_valid = 1'b0; flush = 1'b1; tick();
      chk("fl_out_valid", 160'(out_valid_a), 160'(0));
      chk("fl_occ", 160'(occ_a), 160'(0));
      chk("fl_data", 160'(out_data_a), 160'(0));
      chk("fl_rdy", 160'(in_ready_a), 160'(1));
      chk("fl_stall", 160'(stall_a), 160'(5));
      flush = 1'b0; tick();
      chk("fl_stall_keep", 160'(stall_a), 160'(5));

      // Flush with simultaneous in_fire in ONE
      in_valid = 1'b1; in_data = DW'('hE1); tick();
      chk("fd_one", 160'(occ_a), 160'(1));
      in_data = DW'('hD1); flush = 1'b1; tick();
      chk("fd_empty", 160'(occ_a), 160'(0));
      chk("fd_data", 160'(out_data_a), 160'(0));
      flush = 1'b0; in_valid = 1'b0;
      repeat (3) tick();
      chk("fd_no_d1", 160'(out_valid_a), 160'(0));

      // Saturation on the 4-bit instance
      in_valid = 1'b1; in_data = DW'('hF1); tick();
      chk("sat_start", 160'(stall_b), 160'(6));
      in_valid = 1'b0;
      repeat (20) tick();
      chk("sat4", 160'(stall_b), 160'(15));
      chk("sat16", 160'(stall_a), 160'(26));
      repeat (3) tick();
      chk("sat4_hold", 160'(stall_b), 160'(15));
      rst_n = 1'b0; tick();
      chk("sat4_rst", 160'(stall_b), 160'(0));
      chk("sat16_rst", 160'(stall_a), 160'(0));
      rst_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r         = {$urandom, $urandom, $urandom, $urandom, $urandom};
         in_data   = r[DW-1:0];
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 3) == 0);
         flush     = ($urandom_range(0, 40) == 0);
         rst_n     = ($urandom_range(0, 400) != 0);
         tick();
      end
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised, fully registered pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never creates a combinational ready path.
- Includes synchronous flush and a saturating stall-cycle counter.
- Replaces the pass-through stage registers (EX/MEM, MEM/WB) between pipeline stages; the payload is an opaque DATA_W bundle.
- Default width fits the MEM/WB bundle: regWriteEnable, instruction, PC, execute result, memRead, memory read data = 130 bits.

Parameters:
- DATA_W, 130, payload width in bits.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous flush; discards all held and incoming entries.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept; registered (function of skid state only).
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_W  payload; driven directly from the main register.
- occupancy  output  2  entries held: 0, 1 or 2.
- stall_cycles  output  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (data + valid) and skid register (data + valid).
- Derived outputs: out_valid = main valid; in_ready = !skid valid.
- Reset, rst_n=0 at a clock edge:
  - both valids = 0, both data registers = 0, stall_cycles = 0.
  - Outputs: out_valid=0, in_ready=1, out_data=0, occupancy=0.
  - Reset mid-transfer drops everything; takes priority over flush.
- State machine, encoded by the valid bits:
  - EMPTY (0, 0)
    - in_fire -> main<=in_data, go to ONE.
    - otherwise stay.
  - ONE (1, 0)
    - in_fire & out_fire -> main<=in_data, stay in ONE.
    - in_fire & !out_fire -> skid<=in_data, go to FULL.
    - !in_fire & out_fire -> go to EMPTY.
    - otherwise hold.
  - FULL (1, 1), in_ready=0:
    - out_fire -> main<=skid, skid valid<=0, go to ONE.
    - otherwise hold.
  - Illegal (0, 1) -> recover to EMPTY.
- Latency and throughput:
  - EMPTY to out_valid: 1 cycle.
  - Sustained throughput with out_ready=1: 1 entry/cycle, stays in ONE.
  - Ordering is strictly FIFO; no entry is ever duplicated or lost except by flush or reset.
- Flush (rst_n=1, flush=1):
  - Next state is EMPTY; both valids and data registers cleared to 0.
  - An in_fire in the same cycle is consumed and discarded; in_ready is not masked.
  - An out_fire in the same cycle is still seen downstream (data valid that cycle).
  - Flush has priority over every handshake.
- Stall counter: increments by 1 on each clock edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Unaffected by flush; cleared only by reset.
- Occupancy = main valid + skid valid.
- Data registers load only on the transitions above; otherwise they hold.
- No X propagation: all registers are reset.

Decomposition:
- Package pipe_pkg:
  - typedef enum of states {EMPTY, ONE, FULL};
  - typedef packed struct memwb_payload_t with fields regWriteEnable(1), instruction(32), PC(32), execute_rst(32), memRead(1), memReadRst(32);
  - constant MEMWB_W = $bits(memwb_payload_t) = 130.
- Sub-module sat_counter (parameter W; inputs inc; output count) for stall_cycles.
- Everything else is inline.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, in_data=0x3 -> out_valid=0, in_ready=1, out_data=0, occupancy=0, stall_cycles=0.
- Streaming: out_ready=1; feed 0xA1, 0xA2, 0xA3 on consecutive cycles -> out_data 0xA1, 0xA2, 0xA3 on the following consecutive cycles; occupancy stays 1; in_ready stays 1.
- Back-pressure:
  - out_ready=0; send 0xB1, then 0xB2 -> occupancy=2, in_ready=0 the next cycle; in_valid with 0xB3 is held off; stall_cycles increments each cycle.
  - Raise out_ready -> outputs 0xB1, 0xB2, 0xB3 in order, no loss.
- Flush in FULL: state FULL holding 0xC1, 0xC2; assert flush with in_valid=0 -> next cycle out_valid=0, occupancy=0, out_data=0, in_ready=1; stall_cycles retains its value.
- Flush with simultaneous in_fire of 0xD1 in ONE state -> next cycle EMPTY; 0xD1 never appears on out_data.
- Saturation: CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15 and stays 15; rst_n=0 -> 0.
